// File: rtl/subleq_exec.sv
// Subleq execution responder: turns the awe/bwe/ramwe/pcwe strobes into operand fetch, write-back and branch.
// Optional macro SUBLEQ_RETIRE_CNT_EN adds the retired counter and last_leq outputs.
module subleq_exec #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter logic [AW-1:0] PC_RESET = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          selop,
  input  logic          awe,
  input  logic          bwe,
  input  logic          ramwe,
  input  logic          pcwe,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic [AW-1:0] pc,
  output logic          ready,
  output logic          seq_err,
`ifdef SUBLEQ_RETIRE_CNT_EN
  output logic [15:0]   retired,
  output logic          last_leq,
`endif
  output logic          halt
);

  typedef enum logic [2:0] {
    S_IDLE, S_A_PTR, S_A_VAL, S_B_PTR, S_B_VAL, S_WRITE, S_BRANCH
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_phase;
  logic          r_err;
  logic          r_halt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_addr_a;
  logic [AW-1:0] r_addr_b;
  logic [DW-1:0] r_a_val;
  // Only B - A is consumed downstream, so the raw B value is folded straight into r_diff.
  logic [DW-1:0] r_diff;

  logic [3:0]    w_strb;
  logic          w_any;
  logic          w_phase_ok;
  logic          w_legal;
  logic          w_accept;
  logic          w_err;
  logic          w_leq;
  logic [AW-1:0] w_pc_new;

  assign w_strb     = {awe, bwe, ramwe, pcwe};
  assign w_any      = |w_strb;
  assign ready      = (r_state == S_IDLE) && !r_halt;

  always_comb begin
    w_phase_ok = 1'b0;
    case (r_phase)
      2'd0:    w_phase_ok = awe;
      2'd1:    w_phase_ok = bwe;
      2'd2:    w_phase_ok = ramwe;
      default: w_phase_ok = pcwe;
    endcase
  end

  assign w_legal  = $onehot(w_strb) && w_phase_ok && (selop == bwe);
  assign w_accept = ready && w_legal;
  assign w_err    = w_any && !r_halt && (!ready || !w_legal);

  assign w_leq    = (r_diff == '0) || r_diff[DW-1];
  assign w_pc_new = w_leq ? mem_rdata[AW-1:0] : r_pc + AW'(3);

  always_comb begin
    w_next    = r_state;
    mem_addr  = r_pc;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (awe)        w_next = S_A_PTR;
          else if (bwe)   w_next = S_B_PTR;
          else if (ramwe) w_next = S_WRITE;
          else            w_next = S_BRANCH;
        end
      end
      S_A_PTR: w_next = S_A_VAL;
      S_A_VAL: begin
        mem_addr = r_addr_a;
        w_next   = S_IDLE;
      end
      S_B_PTR: begin
        mem_addr = r_pc + AW'(1);
        w_next   = S_B_VAL;
      end
      S_B_VAL: begin
        mem_addr = r_addr_b;
        w_next   = S_IDLE;
      end
      S_WRITE: begin
        mem_addr  = r_addr_b;
        mem_wdata = r_diff;
        mem_we    = 1'b1;
        w_next    = S_IDLE;
      end
      S_BRANCH: begin
        mem_addr = r_pc + AW'(2);
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_phase <= r_phase + 2'd1;
      if (w_err)    r_err   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= PC_RESET;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_a_val  <= '0;
      r_diff   <= '0;
      r_halt   <= 1'b0;
    end else begin
      case (r_state)
        S_A_PTR: r_addr_a <= mem_rdata[AW-1:0];
        S_A_VAL: r_a_val  <= mem_rdata;
        S_B_PTR: r_addr_b <= mem_rdata[AW-1:0];
        S_B_VAL: r_diff   <= mem_rdata - r_a_val;
        S_BRANCH: begin
          r_pc <= w_pc_new;
          if (w_pc_new == '1) r_halt <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SUBLEQ_RETIRE_CNT_EN
  logic [15:0] r_retired;
  logic        r_last_leq;

  // Only a BRANCH exit counts, so the count naturally holds once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired  <= 16'd0;
      r_last_leq <= 1'b0;
    end else if (r_state == S_BRANCH) begin
      r_retired  <= r_retired + 16'd1;
      r_last_leq <= w_leq;
    end
  end

  assign retired  = r_retired;
  assign last_leq = r_last_leq;
`endif

  assign pc      = r_pc;
  assign seq_err = r_err;
  assign halt    = r_halt;

endmodule

// File: doc/subleq_exec.md
Name: subleq_exec

Overview:
- Execution responder for the Subleq CPU.
- Consumes the one-hot control strobes selop, awe, bwe, ramwe and pcwe, one per frame phase, and performs the matching memory and register work for a single Subleq instruction: mem[B] = mem[B] - mem[A]; if the result is <= 0 then PC = C, else PC = PC + 3.
- Owns PC, operand-address and operand-value registers. Drives the single-port RAM. Reports ready, protocol errors and halt back toward the sequencer.

Parameters:
- DW, 8, data word width (bits).
- AW, 8, address/PC width (bits); AW <= DW.
- PC_RESET, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- selop  in  1  operand select; must be 1 with bwe, 0 with every other strobe.
- awe  in  1  command: fetch operand A.
- bwe  in  1  command: fetch operand B.
- ramwe  in  1  command: write back B - A.
- pcwe  in  1  command: update PC.
- mem_addr  out  AW  RAM address.
- mem_rdata  in  DW  RAM read data, combinational from mem_addr.
- mem_wdata  out  DW  RAM write data.
- mem_we  out  1  RAM write enable.
- pc  out  AW  current program counter.
- ready  out  1  block can accept a strobe this cycle.
- seq_err  out  1  sticky protocol-error flag.
- halt  out  1  sticky halt flag.

Behaviour:
- Reset values (async): pc=PC_RESET; addr_a, addr_b, a_val, b_val, diff = 0; state=IDLE; phase=0; seq_err=0; halt=0; mem_we=0; mem_wdata=0. ready=1 once rst deasserts.
- ready = (state==IDLE) && !halt.
- In IDLE: mem_addr=pc and mem_we=0.
- Strobes are sampled at the clock edge only when ready=1.
- Legal strobe order is awe, bwe, ramwe, pcwe, tracked by a 2-bit phase counter (0..3, wraps to 0 after pcwe).
- An error strobe is any of:
  - more than one strobe high at once;
  - a strobe that does not match the current phase;
  - a wrong selop value;
  - any strobe while ready=0 and halt=0.
- On an error strobe: seq_err<=1 (cleared only by rst); no state, register or RAM change; phase unchanged.
- While halt=1, all strobes are ignored silently; seq_err is not set.
- State machine, one cycle per state:
  - IDLE -awe-> A_PTR -> A_VAL -> IDLE.
  - IDLE -bwe-> B_PTR -> B_VAL -> IDLE.
  - IDLE -ramwe-> WRITE -> IDLE.
  - IDLE -pcwe-> BRANCH -> IDLE.
- A_PTR: mem_addr=pc; addr_a <= mem_rdata[AW-1:0].
- A_VAL: mem_addr=addr_a; a_val <= mem_rdata.
- B_PTR: mem_addr=pc+1; addr_b <= mem_rdata[AW-1:0].
- B_VAL: mem_addr=addr_b; b_val <= mem_rdata; diff <= mem_rdata - a_val.
- WRITE: mem_addr=addr_b; mem_wdata=diff; mem_we=1.
- BRANCH: mem_addr=pc+2.
  - leq = (diff==0) || diff[DW-1].
  - leq: pc <= mem_rdata[AW-1:0]; else pc <= pc+3.
  - If the new pc equals all-ones, halt <= 1 on the same edge.
- Latency: a strobe accepted at edge k returns ready=1 at edge k+2 (fetch) or k+1 (write/branch). A full instruction takes 6 busy cycles plus strobe spacing.
- Arithmetic: diff is modulo 2^DW, two's-complement sign. All PC offsets are modulo 2^AW, so pc+1/+2/+3 wrap.
- Reset mid-operation aborts immediately. No partial RAM write survives after the reset edge; mem_we drops asynchronously.

Optional Feature:
- Macro SUBLEQ_RETIRE_CNT_EN.
- Defined:
  - Extra output retired, 16 bits, reset 0.
  - Increments on every BRANCH-state exit and wraps 0xFFFF->0.
  - Holds while halted.
  - Extra output last_leq, 1 bit, reset 0: the leq value of the most recent branch.
- Undefined: neither port exists and the counter logic is absent. All other behaviour is identical.

Test Plan:
- Taken branch, DW=AW=8. Image mem[0]=10, mem[1]=11, mem[2]=20, mem[10]=5, mem[11]=3. Issue awe, bwe(selop=1), ramwe, pcwe, each after ready. Required: mem[11]=0xFE, pc=20, seq_err=0.
- Untaken branch. Same image with mem[11]=7. Required: mem[11]=0x02, pc=3. With diff=0 (mem[11]=5), required pc=20.
- Order violation. bwe issued first after reset. Required: seq_err=1, pc=0, mem_we never 1; a following correct awe is still accepted (phase 0).
- Busy/overlap violations.
  - awe at edge k, awe again at edge k+1 (ready=0): seq_err=1, second strobe ignored.
  - awe and pcwe in the same cycle: seq_err=1.
- Reset and wrap.
  - rst pulsed during A_VAL: pc=0, ready=1, seq_err=0 immediately after release.
  - pc=0xFE with untaken branch: fetch addresses 0xFE, 0xFF, 0x00, then pc=0x01.
- Halt. Branch target mem[pc+2]=0xFF, taken. Required: halt=1, ready=0; later strobes change nothing and seq_err stays 0. With SUBLEQ_RETIRE_CNT_EN, retired=1 and last_leq=1.
